// File: rtl/commit_trace_collector_if.sv
//============================================================================
// Module      : commit_trace_collector_if
// Description : Commit-event inputs and trace-stream outputs of the collector.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface commit_trace_collector_if #(
  parameter int AW = 4
);
  logic          grf_we;
  logic [31:0]   grf_pc;
  logic [4:0]    grf_addr;
  logic [31:0]   grf_wdata;
  logic          dm_we;
  logic [31:0]   dm_pc;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          out_valid;
  logic          out_ready;
  logic          out_type;
  logic [31:0]   out_pc;
  logic [31:0]   out_addr;
  logic [31:0]   out_data;
  logic          overflow;
  logic [15:0]   drop_cnt;
  logic [AW:0]   level;

  // Core side plus trace consumer
  modport master (
    output grf_we, grf_pc, grf_addr, grf_wdata,
    output dm_we, dm_pc, dm_addr, dm_wdata,
    output out_ready,
    input  out_valid, out_type, out_pc, out_addr, out_data,
    input  overflow, drop_cnt, level
  );

  // Collector side
  modport slave (
    input  grf_we, grf_pc, grf_addr, grf_wdata,
    input  dm_we, dm_pc, dm_addr, dm_wdata,
    input  out_ready,
    output out_valid, out_type, out_pc, out_addr, out_data,
    output overflow, drop_cnt, level
  );
endinterface

`default_nettype wire

// File: rtl/commit_trace_collector.sv
//============================================================================
// Module      : commit_trace_collector
// Description : Captures GRF writes and DM stores into a 2-write/1-read FWFT
//               FIFO and drains them as a valid/ready trace stream.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module commit_trace_collector #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire                      clk,
  input  wire                      reset,
  commit_trace_collector_if.slave  bus
);

  localparam logic [AW+1:0] c_depth = (AW+2)'(DEPTH);

  logic [96:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic [96:0]   r_head;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic          w_grf_v;
  logic          w_dm_v;
  logic          w_pop;
  logic [AW+1:0] w_free;
  logic [1:0]    w_need;
  logic [1:0]    w_n_push;
  logic [1:0]    w_drops;
  logic [96:0]   w_grf_entry;
  logic [96:0]   w_dm_entry;
  logic [96:0]   w_e0;
  logic [AW-1:0] w_wptr_p1;
  logic [AW-1:0] w_rptr_n;
  logic [AW:0]   w_level_n;
  logic [96:0]   w_head_n;
  logic [16:0]   w_drop_sum;

  always_comb begin
    w_grf_v     = bus.grf_we && (bus.grf_addr != 5'd0);
    w_dm_v      = bus.dm_we;
    w_pop       = (r_level != '0) && bus.out_ready;
    w_free      = c_depth - {1'b0, r_level} + (AW+2)'(w_pop);
    w_need      = {1'b0, w_grf_v} + {1'b0, w_dm_v};
    w_n_push    = w_need;
    if (w_free < (AW+2)'(w_need)) begin
      // Only reachable with free<=1, so the low bits are the exact count
      w_n_push = w_free[1:0];
    end
    w_drops     = w_need - w_n_push;
    w_grf_entry = {1'b0, bus.grf_pc, {27'd0, bus.grf_addr}, bus.grf_wdata};
    w_dm_entry  = {1'b1, bus.dm_pc, bus.dm_addr, bus.dm_wdata};
    // The older W-stage event always takes the first slot
    w_e0        = w_grf_v ? w_grf_entry : w_dm_entry;
    w_wptr_p1   = r_wptr + 1'b1;
    w_rptr_n    = r_rptr + AW'(w_pop);
    w_level_n   = r_level + (AW+1)'(w_n_push) - (AW+1)'(w_pop);
    w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drops);

    // Next head must bypass the RAM when it is being written this edge
    w_head_n = r_mem[w_rptr_n];
    if (w_n_push != 2'd0 && w_rptr_n == r_wptr) begin
      w_head_n = w_e0;
    end else if (w_n_push == 2'd2 && w_rptr_n == w_wptr_p1) begin
      w_head_n = w_dm_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (w_n_push != 2'd0) begin
      r_mem[r_wptr] <= w_e0;
    end
    if (w_n_push == 2'd2) begin
      r_mem[w_wptr_p1] <= w_dm_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_n_push);
      r_rptr  <= w_rptr_n;
      r_level <= w_level_n;
      if (w_level_n != '0) begin
        r_head <= w_head_n;
      end
      if (w_drops != 2'd0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      end
    end
  end

  assign bus.out_valid = (r_level != '0);
  assign bus.out_type  = r_head[96];
  assign bus.out_pc    = r_head[95:64];
  assign bus.out_addr  = r_head[63:32];
  assign bus.out_data  = r_head[31:0];
  assign bus.overflow  = r_overflow;
  assign bus.drop_cnt  = r_drop_cnt;
  assign bus.level     = r_level;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_collector.sv
//============================================================================
// Module      : tb_commit_trace_collector
// Description : Directed self-checking bench for commit_trace_collector.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_commit_trace_collector;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  commit_trace_collector_if #(.AW(4)) bus ();

  commit_trace_collector #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.grf_we = 1'b0; bus.grf_pc = '0; bus.grf_addr = '0; bus.grf_wdata = '0;
    bus.dm_we = 1'b0;  bus.dm_pc = '0;  bus.dm_addr = '0;  bus.dm_wdata = '0;
  endtask

  task automatic set_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    bus.grf_we = 1'b1; bus.grf_pc = pc; bus.grf_addr = a; bus.grf_wdata = d;
  endtask

  task automatic set_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    bus.dm_we = 1'b1; bus.dm_pc = pc; bus.dm_addr = a; bus.dm_wdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    set_grf(32'h100, 5'd8, 32'hDEAD);
    tick(); tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 5'd0 || bus.overflow !== 1'b0 || bus.drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b level=%0d ovf=%b drops=%0d, want 0 0 0 0",
               bus.out_valid, bus.level, bus.overflow, bus.drop_cnt);
    end
    checks++;
    if (bus.out_pc !== 32'd0 || bus.out_data !== 32'd0 || bus.out_addr !== 32'd0 || bus.out_type !== 1'b0) begin
      errors++;
      $display("FAIL reset_head: pc=%h addr=%h data=%h type=%b, want all 0",
               bus.out_pc, bus.out_addr, bus.out_data, bus.out_type);
    end
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: valid=%b level=%0d, want 0 0", bus.out_valid, bus.level);
    end
  endtask

  task automatic test_single_grf();
    bus.out_ready = 1'b1;
    set_grf(32'h3000, 5'd8, 32'h1234);
    tick();
    idle_inputs();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_type !== 1'b0 || bus.out_pc !== 32'h3000 ||
        bus.out_addr !== 32'd8 || bus.out_data !== 32'h1234 || bus.level !== 5'd1) begin
      errors++;
      $display("FAIL single_grf: v=%b t=%b pc=%h a=%h d=%h lvl=%0d, want 1 0 3000 8 1234 1",
               bus.out_valid, bus.out_type, bus.out_pc, bus.out_addr, bus.out_data, bus.level);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b level=%0d, want 0 0", bus.out_valid, bus.level);
    end
  endtask

  task automatic test_filter_dual();
    bus.out_ready = 1'b0;
    set_grf(32'h2FF8, 5'd0, 32'h5555);
    set_dm(32'h2FFC, 32'h10, 32'hFF);
    tick();
    idle_inputs();
    checks++;
    if (bus.level !== 5'd1 || bus.out_type !== 1'b1 || bus.out_pc !== 32'h2FFC ||
        bus.out_addr !== 32'h10 || bus.out_data !== 32'hFF) begin
      errors++;
      $display("FAIL zero_filter: lvl=%0d t=%b pc=%h a=%h d=%h, want 1 1 2ffc 10 ff",
               bus.level, bus.out_type, bus.out_pc, bus.out_addr, bus.out_data);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    set_grf(32'h3004, 5'd9, 32'hAAAA);
    set_dm(32'h3008, 32'h20, 32'hBBBB);
    tick();
    idle_inputs();
    checks++;
    if (bus.level !== 5'd2 || bus.out_type !== 1'b0 || bus.out_pc !== 32'h3004 ||
        bus.out_addr !== 32'd9 || bus.out_data !== 32'hAAAA) begin
      errors++;
      $display("FAIL dual_head: lvl=%0d t=%b pc=%h a=%h d=%h, want 2 0 3004 9 aaaa",
               bus.level, bus.out_type, bus.out_pc, bus.out_addr, bus.out_data);
    end
    tick();
    checks++;
    if (bus.level !== 5'd2 || bus.out_pc !== 32'h3004) begin
      errors++;
      $display("FAIL dual_stall: lvl=%0d pc=%h, want 2 3004", bus.level, bus.out_pc);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.level !== 5'd1 || bus.out_type !== 1'b1 || bus.out_pc !== 32'h3008 ||
        bus.out_addr !== 32'h20 || bus.out_data !== 32'hBBBB) begin
      errors++;
      $display("FAIL dual_second: lvl=%0d t=%b pc=%h a=%h d=%h, want 1 1 3008 20 bbbb",
               bus.level, bus.out_type, bus.out_pc, bus.out_addr, bus.out_data);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic fill16(input int base);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      set_grf(32'h4000 + 32'(4 * i), 5'd1, 32'(base + i));
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    fill16(0);
    checks++;
    if (bus.level !== 5'd16 || bus.out_data !== 32'd1) begin
      errors++;
      $display("FAIL wrap_full: lvl=%0d head=%0d, want 16 1", bus.level, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'(k)) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: valid=%b data=%0d, want 1 %0d", k, bus.out_valid, bus.out_data, k);
      end
      if (k <= 5) set_grf(32'h5000, 5'd2, 32'(16 + k));
      else        idle_inputs();
      tick();
    end
    idle_inputs();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.level !== 5'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: lvl=%0d valid=%b ovf=%b, want 0 0 0", bus.level, bus.out_valid, bus.overflow);
    end
  endtask

  task automatic test_overflow();
    fill16(100);
    set_grf(32'h6000, 5'd3, 32'h77);
    set_dm(32'h6004, 32'h40, 32'h88);
    tick();
    idle_inputs();
    checks++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 16'd2 || bus.level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_both: ovf=%b drops=%0d lvl=%0d, want 1 2 16", bus.overflow, bus.drop_cnt, bus.level);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    set_grf(32'h6008, 5'd4, 32'h99);
    set_dm(32'h600C, 32'h44, 32'hAA);
    tick();
    idle_inputs();
    checks++;
    if (bus.drop_cnt !== 16'd3 || bus.level !== 5'd16 || bus.out_data !== 32'd102) begin
      errors++;
      $display("FAIL ovf_partial: drops=%0d lvl=%0d head=%0d, want 3 16 102", bus.drop_cnt, bus.level, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int k = 2; k <= 16; k++) tick();
    checks++;
    if (bus.level !== 5'd1 || bus.out_type !== 1'b0 || bus.out_data !== 32'h99) begin
      errors++;
      $display("FAIL ovf_kept: lvl=%0d t=%b data=%h, want 1 0 99", bus.level, bus.out_type, bus.out_data);
    end
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    fill16(200);
    bus.out_ready = 1'b1;
    set_grf(32'h7000, 5'd5, 32'h300);
    tick();
    idle_inputs();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.level !== 5'd16 || bus.drop_cnt !== 16'd3 || bus.out_data !== 32'd202) begin
      errors++;
      $display("FAIL full_pop: lvl=%0d drops=%0d head=%0d, want 16 3 202", bus.level, bus.drop_cnt, bus.out_data);
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (bus.level !== 5'd0 || bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: lvl=%0d valid=%b ovf=%b drops=%0d, want 0 0 0 0",
               bus.level, bus.out_valid, bus.overflow, bus.drop_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    idle_inputs();
    test_reset();
    test_single_grf();
    test_filter_dual();
    test_wrap();
    test_overflow();
    test_full_pop();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_trace_collector.md
Name: commit_trace_collector

Overview:
- Sink side of the CPU's architectural-commit trace.
- Captures register-file writes (W stage) and data-memory stores (M stage) from the pipelined mips core.
- Buffers the captured events in a FIFO and drains them one per cycle over a valid/ready stream to the trace logger/comparator.
- Makes the commit trace a hardware output instead of a simulation-only display.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 4.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- grf_we  in  1  W-stage register write this cycle.
- grf_pc  in  32  PC of the writing instruction.
- grf_addr  in  5  destination register.
- grf_wdata  in  32  value written.
- dm_we  in  1  M-stage store this cycle.
- dm_pc  in  32  PC of the storing instruction.
- dm_addr  in  32  word-aligned byte address.
- dm_wdata  in  32  stored word.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry.
- out_type  out  1  0 = GRF event, 1 = DM event.
- out_pc  out  32  event PC.
- out_addr  out  32  GRF: zero-extended 5-bit register number; DM: address.
- out_data  out  32  event data.
- overflow  out  1  sticky; an event was dropped.
- drop_cnt  out  16  number of dropped events, saturating.
- level  out  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Read pointer, write pointer and level go to 0.
  - out_valid=0, overflow=0, drop_cnt=0.
  - out_type/out_pc/out_addr/out_data=0.
  - FIFO RAM contents are don't-care.
  - Reset applied mid-operation discards all entries; no partial drain.
- Event qualification:
  - A GRF event is valid when grf_we=1 and grf_addr!=0. Writes to $0 are never recorded.
  - A DM event is valid when dm_we=1.
- Enqueue order when both are valid in the same cycle:
  - The GRF event is enqueued first, then the DM event.
  - Reason: the W-stage instruction is older than the M-stage one.
  - Up to 2 entries are written per cycle.
- Free space:
  - free = DEPTH - level + (out_valid & out_ready).
  - A pop in the same cycle frees a slot for that cycle's pushes.
- Space rules:
  - free>=needed: all events enqueued.
  - free==1 with two events: GRF enqueued, DM dropped.
  - free==0: all events dropped.
  - Each dropped event sets overflow=1 and increments drop_cnt by 1, saturating at 16'hFFFF.
  - Two drops in one cycle add 2, still saturating.
- Entry format: {type, pc, addr, data}, 97 bits. Pointers wrap modulo DEPTH.
- Outputs:
  - Registered from the FIFO head (first-word-fall-through).
  - out_valid = (level!=0).
  - The head fields are stable while out_valid=1 and out_ready=0.
  - A pop happens on a clk edge where out_valid & out_ready; the next head appears on the following cycle.
- Latency: an event enqueued into an empty FIFO at edge N gives out_valid=1 after edge N (visible in cycle N+1).
- Per-edge level update: level_next = level + pushes - pop. Simultaneous push and pop at level==DEPTH is legal: the pop frees space (see free).
- out_ready while out_valid=0: ignored.
- overflow and drop_cnt clear only on reset.

Test Plan:
- Reset to idle: hold reset=0 for 2 cycles with grf_we=1 -> out_valid=0, level=0, overflow=0, drop_cnt=0; release reset -> still idle until an event arrives.
- Single GRF event: grf_we=1, pc=32'h3000, addr=5'd8, wdata=32'h1234, out_ready=1 -> the next cycle shows out_valid=1, type=0, pc=3000, addr=8, data=1234; popped on that edge, level back to 0.
- $0 filter and dual event:
  - grf_addr=0 with dm_we=1 (addr=32'h10, data=32'hFF) -> only the DM entry is enqueued.
  - Then both valid together (grf pc=3004 and dm pc=3008) with out_ready=0 -> the GRF entry is at the head, the DM entry next, level=2.
- Back-pressure and wrap: out_ready=0, push 16 GRF events with data 1..16 -> level=16; then drain with out_ready=1 while pushing 5 more -> output data sequence 1..21 in order across the pointer wrap.
- Overflow:
  - At level=16, out_ready=0, one dual event -> both dropped, overflow=1, drop_cnt=2.
  - At level=15, one dual event -> GRF kept, DM dropped, drop_cnt=3.
- Full with simultaneous pop: level=16, out_ready=1, single grf event -> accepted, no drop, level stays 16.
